rd_mem: RTL and testbench
=========================

Name: rd_mem

Overview:
- Read-side counterpart of the frame-buffer line writer.
- On a line request from the display side, issues READ bursts to one DRAM controller user port (command port plus read-data FIFO).
- Drains each 64-word burst from the controller read FIFO into the downstream line FIFO.
- Uses the same address map as the writer, {5'd0, vsel, line[10:0], hbyte[12:0]}, so lines written by the writer are read back verbatim.

Parameters:
- DISP_HSTART, 0, horizontal pixel offset; start byte = DISP_HSTART*2 (16-bit pixels).
- DISP_VSTART, 0, added to requested line number (11-bit, wraps mod 2048).
- NBURST, 4, bursts per line (each burst 64 x 128 bit = 1024 B); legal range 1..8.

Ports:
- cmd_clk  in  1  single clock, controller command/read clock.
- rst_n  in  1  asynchronous active-low reset.
- calib_done  in  1  DRAM calibration complete.
- cmd_en  out  1  command strobe, one cycle per burst.
- cmd_instr  out  3  constant 3'd1 (READ).
- cmd_bl  out  6  constant 6'd63.
- cmd_byte_addr  out  30  burst byte address.
- cmd_full  in  1  command FIFO full.
- rd_en  out  1  read-data FIFO pop.
- rd_data  in  128  read-data FIFO head.
- rd_empty  in  1  read-data FIFO empty.
- rd_overflow  in  1  controller read overflow.
- rd_error  in  1  controller read error.
- arb_state  in  2  port arbiter; 2'b01 grants the read port.
- req  in  1  line request pulse, sampled only in IDLE.
- rline  in  11  requested line number, captured with req.
- rsel  in  1  video input select; 0 maps to vsel=1, 1 maps to vsel=0 (matches writer csel).
- odata  out  128  word to line FIFO.
- owr_en  out  1  line FIFO write strobe.
- ofull  in  1  line FIFO full.
- busy  out  1  high from req accept until done.
- done  out  1  one-cycle pulse when the line is complete.
- err  out  1  sticky error flag.
- debug  out  8  {err, busy, ofull, rd_empty, rd_en, state[2:0]}.

Behaviour:
- Reset (async, rst_n=0) or calib_done=0: state=IDLE; cmd_en, rd_en, owr_en, done, busy, err = 0; cmd_byte_addr=0; odata=0; word and burst counters = 0. Reset mid-burst abandons the line; no further commands or pops are issued.
- IDLE: req=1 latches line = rline+DISP_VSTART, vsel = ~rsel, hbyte = DISP_HSTART*2, bcnt=0. Sets busy=1, goes to CMD. req outside IDLE is ignored.
- CMD: when arb_state==2'b01 and ~cmd_full:
  - cmd_en=1 for exactly one cycle.
  - cmd_byte_addr = {5'd0, vsel, line, hbyte} registered with cmd_en.
  - Go to RDD with wcnt=0.
  - Otherwise hold with cmd_en=0.
- RDD:
  - rd_en = ~rd_empty & ~ofull & (wcnt<64), combinational.
  - Each pop: owr_en=1 next cycle with odata = rd_data from the pop cycle (1-cycle latency), and wcnt++.
  - When wcnt reaches 64: hbyte += 1024 (13-bit, wraps), bcnt++.
  - If bcnt == NBURST-1 at that point, go to DONE; else go to CMD.
  - ofull=1 stalls pops only; no data is dropped and the command is not reissued.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A req in the DONE cycle is ignored.
- err: set if rd_overflow or rd_error is seen in any state. Cleared only by reset. Sequencing is unaffected.
- Rules:
  - At most one outstanding burst.
  - Never more than 64 pops per command.
  - cmd_en never asserts outside CMD.
  - rd_en never asserts while rd_empty=1.

Test Plan:
- Basic line, NBURST=4, DISP_HSTART=0, DISP_VSTART=0: req with rline=5, rsel=0, arb=01 -> 4 cmd_en pulses, addrs 0x0100A000, 0x0100A400, 0x0100A800, 0x0100AC00; 256 owr_en with data in order; one done pulse.
- Offset/wrap, DISP_HSTART=3968, DISP_VSTART=10: req with rline=2040, rsel=1 -> line=2, first addr {5'd0, 1'b0, 11'd2, 13'd7936}, second hbyte wraps to 13'd768.
- Arbiter/cmd_full stall: arb_state=2'b10 for 20 cycles then 01, with cmd_full pulsed -> cmd_en only once both are satisfied; no duplicate commands.
- Backpressure: ofull toggling randomly and rd_empty gaps -> exactly 64 words per burst, order preserved, rd_en never high with rd_empty or ofull high.
- Error/ignore: rd_overflow pulse mid-line -> err=1 sticky, line still completes; req during busy -> ignored, no extra commands.
- Async reset mid-RDD: rst_n low after word 30 of burst 2 -> all outputs 0 immediately; after release, a new req starts at burst 0.

Source files
------------

// File: rtl/rd_mem.sv
// Frame-buffer line reader: issues READ bursts for one display line and drains
// each 64-word burst from the DRAM controller read FIFO into the line FIFO.
module rd_mem #(
   parameter int DISP_HSTART = 0,
   parameter int DISP_VSTART = 0,
   parameter int NBURST      = 4
) (
   input  logic         cmd_clk,
   input  logic         rst_n,
   input  logic         calib_done,
   output logic         cmd_en,
   output logic [2:0]   cmd_instr,
   output logic [5:0]   cmd_bl,
   output logic [29:0]  cmd_byte_addr,
   input  logic         cmd_full,
   output logic         rd_en,
   input  logic [127:0] rd_data,
   input  logic         rd_empty,
   input  logic         rd_overflow,
   input  logic         rd_error,
   input  logic [1:0]   arb_state,
   input  logic         req,
   input  logic [10:0]  rline,
   input  logic         rsel,
   output logic [127:0] odata,
   output logic         owr_en,
   input  logic         ofull,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [7:0]   debug
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_RDD  = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;

   localparam logic [12:0] HSTART_BYTE = 13'(DISP_HSTART * 2);
   localparam logic [10:0] VSTART_LINE = 11'(DISP_VSTART);
   localparam logic [2:0]  LAST_BURST  = 3'(NBURST - 1);

   logic [2:0]  state;
   logic [10:0] line;
   logic        vsel;
   logic [12:0] hbyte;
   logic [2:0]  bcnt;
   logic [6:0]  wcnt;
   logic        grant;

   assign grant     = (arb_state == 2'b01) && !cmd_full;
   assign cmd_instr = 3'd1;
   assign cmd_bl    = 6'd63;

   // The address is composed straight from the line/hbyte registers, so it is
   // stable for the whole CMD state and reads 0 out of reset.
   assign cmd_byte_addr = {5'd0, vsel, line, hbyte};

   // NOTE: cmd_en and rd_en are combinational so the strobe and the FIFO status
   // it depends on are sampled by the controller on the same edge.
   assign cmd_en = calib_done && (state == S_CMD) && grant;
   assign rd_en  = calib_done && (state == S_RDD) && !rd_empty && !ofull && !wcnt[6];
   assign busy   = calib_done && ((state == S_CMD) || (state == S_RDD));
   assign done   = calib_done && (state == S_DONE);
   assign debug  = {err, busy, ofull, rd_empty, rd_en, state};

   // NOTE: all state uses non-blocking assignments so every register sees the
   // pre-edge value of every other register.
   always_ff @(posedge cmd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         line   <= '0;
         vsel   <= 1'b0;
         hbyte  <= '0;
         bcnt   <= '0;
         wcnt   <= '0;
         owr_en <= 1'b0;
         odata  <= '0;
         err    <= 1'b0;
      end else if (!calib_done) begin
         state  <= S_IDLE;
         line   <= '0;
         vsel   <= 1'b0;
         hbyte  <= '0;
         bcnt   <= '0;
         wcnt   <= '0;
         owr_en <= 1'b0;
         odata  <= '0;
         err    <= 1'b0;
      end else begin
         owr_en <= rd_en;
         if (rd_en) odata <= rd_data;
         if (rd_overflow || rd_error) err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (req) begin
                  line  <= rline + VSTART_LINE;
                  vsel  <= ~rsel;
                  hbyte <= HSTART_BYTE;
                  bcnt  <= '0;
                  wcnt  <= '0;
                  state <= S_CMD;
               end
            end
            S_CMD: begin
               if (grant) begin
                  wcnt  <= '0;
                  state <= S_RDD;
               end
            end
            S_RDD: begin
               if (rd_en) begin
                  wcnt <= wcnt + 7'd1;
               end else if (wcnt[6]) begin
                  // Burst fully drained: advance one 1 KiB burst along the line.
                  hbyte <= hbyte + 13'd1024;
                  bcnt  <= bcnt + 3'd1;
                  state <= (bcnt == LAST_BURST) ? S_DONE : S_CMD;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rd_mem.sv
// Self-checking bench for rd_mem: a queue-based controller/FIFO model drives
// randomized traffic and every cycle's outputs are compared against it.
module tb_rd_mem;

   localparam int NB = 4;

   logic cmd_clk = 1'b0;
   always #5 cmd_clk = ~cmd_clk;

   logic         rst_n, calib_done;
   logic         cmd_en, cmd_full, rd_en, rd_empty, rd_overflow, rd_error;
   logic [2:0]   cmd_instr;
   logic [5:0]   cmd_bl;
   logic [29:0]  cmd_byte_addr;
   logic [127:0] rd_data, odata;
   logic [1:0]   arb_state;
   logic         req, rsel, owr_en, ofull, busy, done, err;
   logic [10:0]  rline;
   logic [7:0]   debug;

   logic         o_cmd_en, o_rd_en, o_req, o_rsel, o_owr_en, o_busy, o_done, o_err;
   logic [2:0]   o_cmd_instr;
   logic [5:0]   o_cmd_bl;
   logic [29:0]  o_cmd_byte_addr;
   logic [127:0] o_rd_data, o_odata;
   logic [10:0]  o_rline;
   logic [7:0]   o_debug;

   rd_mem #(.DISP_HSTART(0), .DISP_VSTART(0), .NBURST(NB)) u_dut (
      .cmd_clk(cmd_clk), .rst_n(rst_n), .calib_done(calib_done),
      .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
      .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
      .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
      .rd_overflow(rd_overflow), .rd_error(rd_error), .arb_state(arb_state),
      .req(req), .rline(rline), .rsel(rsel), .odata(odata), .owr_en(owr_en),
      .ofull(ofull), .busy(busy), .done(done), .err(err), .debug(debug)
   );

   rd_mem #(.DISP_HSTART(3968), .DISP_VSTART(10), .NBURST(4)) u_off (
      .cmd_clk(cmd_clk), .rst_n(rst_n), .calib_done(1'b1),
      .cmd_en(o_cmd_en), .cmd_instr(o_cmd_instr), .cmd_bl(o_cmd_bl),
      .cmd_byte_addr(o_cmd_byte_addr), .cmd_full(1'b0),
      .rd_en(o_rd_en), .rd_data(o_rd_data), .rd_empty(1'b0),
      .rd_overflow(1'b0), .rd_error(1'b0), .arb_state(2'b01),
      .req(o_req), .rline(o_rline), .rsel(o_rsel), .odata(o_odata), .owr_en(o_owr_en),
      .ofull(1'b0), .busy(o_busy), .done(o_done), .err(o_err), .debug(o_debug)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line/controller model state
   bit           line_active, burst_open, record;
   int           bursts_cmded, pops, owr_total, to_deliver, done_cnt;
   logic [127:0] rdq[$];
   logic [127:0] last_word;
   logic [29:0]  line_addrs[$];
   logic [10:0]  acc_rline;
   logic         acc_rsel;
   bit           p_pop, p_cmd, p_accept, p_ovf, prev_pop, err_m;
   bit           req_pend, inject_ovf, inject_err;
   int           p_deliver, p_ofull, p_cmdfull, arb_mode, stall_cnt;

   // Offset-instance monitor state
   bit           o_req_pend, o_p_pop;
   logic [127:0] o_seq, o_exp_seq;
   int           o_words, o_done_cnt;
   logic [29:0]  o_addrs[$];

   function automatic logic [29:0] exp_addr(input logic [10:0] rl, input logic rs,
                                            input int k, input int hstart, input int vstart);
      int ln, hb, vs;
      ln = (int'(rl) + vstart) % 2048;
      hb = (hstart * 2 + k * 1024) % 8192;
      vs = rs ? 0 : 1;
      return 30'(vs * 16777216 + ln * 8192 + hb);
   endfunction

   task automatic step();
      bit can_cmd, exp_rd;
      @(negedge cmd_clk);
      // Apply what happened on the edge just passed.
      prev_pop = p_pop;
      if (p_pop) begin
         last_word = (rdq.size() > 0) ? rdq.pop_front() : 'x;
         pops++;
         if (pops == 64) burst_open = 1'b0;
      end
      if (p_cmd) begin
         burst_open = 1'b1;
         pops = 0;
         bursts_cmded++;
         to_deliver = 64;
      end
      if (p_accept) begin
         line_active  = 1'b1;
         bursts_cmded = 0;
         burst_open   = 1'b0;
         owr_total    = 0;
      end
      if (p_ovf) err_m = 1'b1;
      if (o_p_pop) o_seq++;

      // Controller produces read data at a random rate.
      if (to_deliver > 0 && $urandom_range(99) < p_deliver) begin
         rdq.push_back({$urandom, $urandom, $urandom, $urandom});
         to_deliver--;
      end

      rd_empty = (rdq.size() == 0);
      rd_data  = rd_empty ? {$urandom, $urandom, $urandom, $urandom} : rdq[0];
      ofull    = ($urandom_range(99) < p_ofull);
      cmd_full = ($urandom_range(99) < p_cmdfull);
      case (arb_mode)
         0: arb_state = 2'b01;
         1: begin
            if (stall_cnt > 0) begin
               arb_state = 2'b10;
               stall_cnt--;
            end else begin
               arb_state = 2'b01;
            end
         end
         default: arb_state = 2'($urandom_range(3));
      endcase
      rd_overflow = inject_ovf;
      rd_error    = inject_err;
      inject_ovf  = 1'b0;
      inject_err  = 1'b0;
      req         = req_pend;
      req_pend    = 1'b0;
      o_req       = o_req_pend;
      o_req_pend  = 1'b0;
      o_rd_data   = o_seq;

      #1;
      exp_rd = rst_n && calib_done && burst_open && (pops < 64) && !rd_empty && !ofull;
      check("rd_en", rd_en, exp_rd);
      check("owr_en", owr_en, prev_pop);
      if (owr_en && prev_pop) check("odata", odata, last_word);
      if (owr_en) owr_total++;
      check("err", err, err_m);
      check("debug", {debug[7], debug[5:3]}, {err_m, ofull, rd_empty, exp_rd});

      if (cmd_en) begin
         can_cmd = line_active && !burst_open && (bursts_cmded < NB) &&
                   (arb_state == 2'b01) && !cmd_full;
         check("cmd_legal", can_cmd, 1'b1);
         check("cmd_addr", cmd_byte_addr, exp_addr(acc_rline, acc_rsel, bursts_cmded, 0, 0));
         check("cmd_instr", cmd_instr, 3'd1);
         check("cmd_bl", cmd_bl, 6'd63);
         if (record) line_addrs.push_back(cmd_byte_addr);
      end

      p_accept = req && !line_active && rst_n && calib_done;
      if (p_accept) begin
         acc_rline = rline;
         acc_rsel  = rsel;
      end

      if (done) begin
         check("done_legal", line_active && (bursts_cmded == NB) && !burst_open &&
               (owr_total == 64 * NB), 1'b1);
         check("busy_at_done", busy, 1'b0);
         done_cnt++;
         line_active = 1'b0;
      end else begin
         check("busy", busy, line_active);
      end

      p_pop = rd_en && rst_n;
      p_cmd = cmd_en && rst_n;
      p_ovf = (rd_overflow || rd_error) && rst_n;

      if (o_cmd_en) o_addrs.push_back(o_cmd_byte_addr);
      if (o_owr_en) begin
         check("off_odata", o_odata, o_exp_seq);
         o_exp_seq++;
         o_words++;
      end
      if (o_done) o_done_cnt++;
      o_p_pop = o_rd_en && rst_n;
   endtask

   task automatic wait_done(input int limit);
      int start, n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < limit) begin
         step();
         n++;
      end
      check("line_timeout", done_cnt != start, 1'b1);
   endtask

   task automatic run_line(input logic [10:0] rl, input logic rs);
      rline    = rl;
      rsel     = rs;
      req_pend = 1'b1;
      step();
      wait_done(20000);
      check("line_words", owr_total, 64 * NB);
      check("line_cmds", bursts_cmded, NB);
   endtask

   task automatic clear_model();
      line_active = 0; burst_open = 0; bursts_cmded = 0; pops = 0; to_deliver = 0;
      rdq.delete();
      p_pop = 0; p_cmd = 0; p_accept = 0; p_ovf = 0; prev_pop = 0; err_m = 0;
      o_p_pop = 0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; calib_done = 1'b1;
      cmd_full = 0; rd_empty = 1; rd_overflow = 0; rd_error = 0; rd_data = '0;
      arb_state = 2'b01; req = 0; rline = '0; rsel = 0; ofull = 0;
      o_req = 0; o_rline = '0; o_rsel = 0; o_rd_data = '0;
      o_seq = '0; o_exp_seq = '0; o_words = 0; o_done_cnt = 0;
      req_pend = 0; o_req_pend = 0; inject_ovf = 0; inject_err = 0; record = 0;
      p_deliver = 100; p_ofull = 0; p_cmdfull = 0; arb_mode = 0; stall_cnt = 0;
      owr_total = 0; done_cnt = 0; acc_rline = '0; acc_rsel = 0;
      clear_model();

      repeat (3) step();
      check("rst_cmd_en", cmd_en, 1'b0);
      check("rst_cmd_addr", cmd_byte_addr, 30'd0);
      check("rst_odata", odata, 128'd0);
      check("rst_done", done, 1'b0);
      rst_n = 1'b1;
      repeat (2) step();

      // Basic line on the default instance, offset/wrap line on the other.
      record = 1;
      o_rline = 11'd2040; o_rsel = 1'b1; o_req_pend = 1'b1;
      run_line(11'd5, 1'b0);
      record = 0;
      check("basic_n_addr", line_addrs.size(), 4);
      if (line_addrs.size() == 4) begin
         check("basic_addr0", line_addrs[0], 30'h0100A000);
         check("basic_addr1", line_addrs[1], 30'h0100A400);
         check("basic_addr2", line_addrs[2], 30'h0100A800);
         check("basic_addr3", line_addrs[3], 30'h0100AC00);
      end
      repeat (4) step();
      check("off_n_addr", o_addrs.size(), 4);
      if (o_addrs.size() == 4) begin
         check("off_addr0", o_addrs[0], 30'h00005F00);
         check("off_addr1", o_addrs[1], 30'h00004300);
         check("off_addr2", o_addrs[2], 30'h00004700);
         check("off_addr3", o_addrs[3], 30'h00004B00);
      end
      check("off_words", o_words, 256);
      check("off_done", o_done_cnt, 1);

      // Arbiter held elsewhere for 20 cycles, with cmd_full pulsing.
      arb_mode = 1; stall_cnt = 20; p_cmdfull = 30;
      run_line(11'd100, 1'b1);

      // Random backpressure on every handshake.
      arb_mode = 2; p_cmdfull = 20; p_deliver = 40; p_ofull = 40;
      for (int i = 0; i < 4; i++) run_line(11'($urandom_range(2047)), 1'($urandom_range(1)));

      // Overflow mid-line plus a req while busy.
      p_deliver = 70; p_ofull = 20;
      rline = 11'd7; rsel = 1'b0; req_pend = 1'b1;
      repeat (60) step();
      inject_ovf = 1'b1;
      step();
      rline = 11'd999; req_pend = 1'b1;
      step();
      wait_done(20000);
      check("err_line_cmds", bursts_cmded, NB);
      inject_err = 1'b1;
      repeat (5) step();
      check("err_sticky", err, 1'b1);
      check("err_idle", busy, 1'b0);

      // Async reset 30 words into burst 2.
      rline = 11'd300; rsel = 1'b1; req_pend = 1'b1;
      step();
      n = 0;
      while (!(bursts_cmded == 3 && pops == 30) && n < 20000) begin
         step();
         n++;
      end
      check("rst_reach_timeout", n < 20000, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cmd_en", cmd_en, 1'b0);
      check("arst_rd_en", rd_en, 1'b0);
      check("arst_owr_en", owr_en, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_err", err, 1'b0);
      check("arst_addr", cmd_byte_addr, 30'd0);
      check("arst_odata", odata, 128'd0);
      clear_model();
      repeat (2) step();
      rst_n = 1'b1;
      step();
      line_addrs.delete();
      record = 1;
      run_line(11'd12, 1'b0);
      record = 0;
      check("post_rst_n_addr", line_addrs.size(), 4);
      if (line_addrs.size() > 0) check("post_rst_addr0", line_addrs[0], 30'h01018000);
      check("post_rst_err", err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
